rx_gate_sequencer: RTL and testbench
====================================

RX_GATE_SEQUENCER -- requirements
Module: rx_gate_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 7'd80, serial address of CTRL; DELAY, WIDTH, IPP and COUNT follow at BASE_ADDR+1 to BASE_ADDR+4.
REQ-002 clock  input  1  single clock domain, the 64 MHz DSP clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high; the block has one clock and this synchronous active-high reset only.
REQ-004 serial_strobe  input  1  one-cycle register write strobe.
REQ-005 serial_addr  input  7  register address.
REQ-006 serial_data  input  32  register write data.
REQ-007 rxstrobe  input  1  one-cycle sample strobe; it is the time base for every count.
REQ-008 trig_in  input  1  external trigger from a daughterboard pin; asynchronous to clock.
REQ-009 gate_enable  output  1  receive-window gate to the RX buffer.
REQ-010 busy  output  1  high in DELAY, WINDOW or HOLDOFF.
REQ-011 done  output  1  high in DONE.
REQ-012 window_count  output  16  number of completed windows since arm.
REQ-013 trig_missed  output  16  count of triggers dropped while busy; saturates at 16'hFFFF.

Function
REQ-014 Registers: CTRL[0]=enable, CTRL[1]=int_mode (1 = internal trigger), CTRL[2]=invert trig_in; DELAY, WIDTH and IPP use [23:0]; COUNT uses [15:0], where 0 means continuous.
REQ-015 A write occurs when serial_strobe=1 and serial_addr matches; the register updates on that clock edge.
REQ-016 trig_in passes through a 2-FF synchronizer and then a rising-edge detector; a trigger event occurs 3 clocks after the pin edge.
REQ-017 In internal mode, an IPP counter advances on rxstrobe and emits one trigger event each time it reaches IPP-1, then wraps to 0; IPP=0 produces no triggers; the external trigger is ignored in this mode.
REQ-018 States: IDLE, ARMED, DELAY, WINDOW, HOLDOFF, DONE.
REQ-019 Transitions:
- IDLE->ARMED when enable=1; this also clears window_count, trig_missed and the IPP counter.
- ARMED->DELAY on a trigger event; DELAY, WIDTH and COUNT are latched into shadow registers at that moment.
- DELAY->WINDOW after DELAY rxstrobes; if DELAY=0, the transition happens on the clock after the trigger.
- WINDOW->HOLDOFF after WIDTH rxstrobes.
- HOLDOFF->ARMED after one clock, with window_count incremented; if COUNT≠0 and window_count reaches COUNT, go to DONE instead.
REQ-020 A trigger event with shadow WIDTH=0 returns to ARMED with no gate and no count.
REQ-021 gate_enable is registered and is high exactly while in WINDOW; WIDTH=N yields a gate covering exactly N rxstrobe pulses.
REQ-022 A trigger event in DELAY, WINDOW or HOLDOFF is ignored and increments trig_missed (saturating).
REQ-023 A trigger coincident with the transition into ARMED is accepted.
REQ-024 When enable=0 in any state, the next state is IDLE and gate_enable drops on the next clock edge; counters hold their values.
REQ-025 DONE is left only when enable=0 (to IDLE) or when COUNT is written (to ARMED, counters cleared).
REQ-026 Register writes during a window do not affect it; they take effect at the next trigger event.
REQ-027 window_count wraps at 16'hFFFF in continuous mode.

Reset
REQ-028 Reset sets all registers, the synchronizer, the IPP counter, window_count and trig_missed to 0, and sets state to IDLE.
REQ-029 Reset sets gate_enable, busy and done to 0 on the same edge; an asserted reset mid-window truncates the window immediately.

Structure
REQ-030 Register offsets, CTRL bit positions and state encodings go in a shared include alongside the standard FPGA register definitions; BASE_ADDR defaults to the FR_GATE_CTRL define in that include.
REQ-031 One sub-module, trig_sync (2-FF synchronizer with rising-edge detect and optional invert), is natural; everything else is one FSM with its counters.

Verification
REQ-032 Test: rxstrobe every 4 clocks; DELAY=10, WIDTH=20, external trigger pulse. Expected: gate rises 3 clocks plus 10 rxstrobes after the edge, gate high for exactly 20 rxstrobes, window_count=1.
REQ-033 Test: internal mode, IPP=100, DELAY=0, WIDTH=5, COUNT=3. Expected: 3 gates spaced 100 rxstrobes apart, then done=1, gate stays 0.
REQ-034 Test: 4 extra triggers during WINDOW. Expected: trig_missed=4 and the window is unaltered; force 70000 misses and expect trig_missed=16'hFFFF.
REQ-035 Test: clear enable mid-WINDOW. Expected: gate_enable=0 on the next clock, state IDLE; re-enable clears the counters.
REQ-036 Test: WIDTH written to 50 mid-window with WIDTH=20 active. Expected: the current window lasts 20 rxstrobes and the next lasts 50.
REQ-037 Test: reset asserted in DELAY and in WINDOW. Expected: all outputs 0 on the following edge; WIDTH=0 trigger produces no gate and no count.

Source files
------------

// File: rtl/rx_gate_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_gate_sequencer_pkg
// Description : Shared register map, control-bit positions, FSM state
//               encoding and helpers for the RX gate sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_gate_sequencer_pkg;

  // Serial address of the CTRL register in the standard FPGA register map.
  localparam logic [6:0] FR_GATE_CTRL = 7'd80;

  // Register offsets relative to BASE_ADDR.
  localparam logic [6:0] OFS_CTRL  = 7'd0;
  localparam logic [6:0] OFS_DELAY = 7'd1;
  localparam logic [6:0] OFS_WIDTH = 7'd2;
  localparam logic [6:0] OFS_IPP   = 7'd3;
  localparam logic [6:0] OFS_COUNT = 7'd4;

  // CTRL bit positions.
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_INT_MODE = 1;
  localparam int CTRL_INVERT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_WINDOW  = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_gate_sequencer_trig_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_gate_sequencer_trig_sync
// Description : Two-flop synchronizer for the asynchronous trigger pin with
//               optional polarity inversion and a rising-edge detector.
//               A pin edge produces a one-clock pulse on 'rise' that is
//               consumed by the sequencer on the third clock edge.
// Ports       : clock  - DSP clock
//               reset  - synchronous active-high reset
//               pin    - asynchronous trigger input
//               invert - 1 = trigger on the falling pin edge
//               rise   - one-clock trigger event pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rx_gate_sequencer_trig_sync (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  input  logic invert,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= pin ^ invert;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule
`default_nettype wire

// File: rtl/rx_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rx_gate_sequencer
// Description : Trigger-driven receive-window sequencer. After a trigger
//               (external pin or internal pulse-period counter) it waits
//               DELAY rxstrobes, opens gate_enable for WIDTH rxstrobes,
//               counts the window and re-arms, optionally stopping after
//               COUNT windows. Triggers arriving while busy are counted.
// Ports       : clock, reset                    - clock / sync reset
//               serial_strobe/addr/data          - register write bus
//               rxstrobe                         - sample-rate time base
//               trig_in                          - async external trigger
//               gate_enable                      - receive window gate
//               busy, done                       - sequencer status
//               window_count, trig_missed        - statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module rx_gate_sequencer
  import rx_gate_sequencer_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR = FR_GATE_CTRL
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        rxstrobe,
  input  logic        trig_in,
  output logic        gate_enable,
  output logic        busy,
  output logic        done,
  output logic [15:0] window_count,
  output logic [15:0] trig_missed
);

  localparam logic [6:0] ADDR_CTRL  = BASE_ADDR + OFS_CTRL;
  localparam logic [6:0] ADDR_DELAY = BASE_ADDR + OFS_DELAY;
  localparam logic [6:0] ADDR_WIDTH = BASE_ADDR + OFS_WIDTH;
  localparam logic [6:0] ADDR_IPP   = BASE_ADDR + OFS_IPP;
  localparam logic [6:0] ADDR_COUNT = BASE_ADDR + OFS_COUNT;

  // Programmable registers
  logic [2:0]  ctrl;
  logic [23:0] delay_reg, width_reg, ipp_reg;
  logic [15:0] count_reg;
  logic        count_wr;
  logic        unused_data;

  assign count_wr    = serial_strobe && (serial_addr == ADDR_COUNT);
  assign unused_data = ^serial_data[31:24];

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl      <= '0;
      delay_reg <= '0;
      width_reg <= '0;
      ipp_reg   <= '0;
      count_reg <= '0;
    end else if (serial_strobe) begin
      if (serial_addr == ADDR_CTRL)  ctrl      <= serial_data[2:0];
      if (serial_addr == ADDR_DELAY) delay_reg <= serial_data[23:0];
      if (serial_addr == ADDR_WIDTH) width_reg <= serial_data[23:0];
      if (serial_addr == ADDR_IPP)   ipp_reg   <= serial_data[23:0];
      if (count_wr)                  count_reg <= serial_data[15:0];
    end
  end

  logic enable, int_mode;
  assign enable   = ctrl[CTRL_ENABLE];
  assign int_mode = ctrl[CTRL_INT_MODE];

  // Trigger sources
  logic ext_rise;

  rx_gate_sequencer_trig_sync u_trig_sync (
    .clock  (clock),
    .reset  (reset),
    .pin    (trig_in),
    .invert (ctrl[CTRL_INVERT]),
    .rise   (ext_rise)
  );

  state_t      state, state_next;
  logic [23:0] cnt, cnt_next;
  logic [23:0] sh_delay, sh_delay_next;
  logic [23:0] sh_width, sh_width_next;
  logic [15:0] sh_count, sh_count_next;
  logic [15:0] wcount, wcount_next;
  logic [15:0] missed, missed_next;
  logic [23:0] ipp_cnt, ipp_cnt_next;
  logic        gate_q;
  logic        ipp_run, ipp_fire, trig_evt;

  assign busy = (state == ST_DELAY) || (state == ST_WINDOW) || (state == ST_HOLDOFF);
  assign done = (state == ST_DONE);

  // The pulse-period counter runs from arm until DONE so windows stay on a
  // fixed grid regardless of how long each window lasts. The >= compare
  // recovers immediately if IPP is reduced below the current count.
  assign ipp_run  = int_mode && ((state == ST_ARMED) || busy);
  assign ipp_fire = ipp_run && rxstrobe && (ipp_reg != 24'd0) &&
                    (ipp_cnt >= ipp_reg - 24'd1);
  assign trig_evt = int_mode ? ipp_fire : ext_rise;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    sh_delay_next = sh_delay;
    sh_width_next = sh_width;
    sh_count_next = sh_count;
    wcount_next   = wcount;
    missed_next   = missed;
    ipp_cnt_next  = ipp_cnt;

    if (!enable) begin
      // Disable wins from any state; counters are left untouched.
      state_next = ST_IDLE;
    end else begin
      if (ipp_run && rxstrobe) begin
        ipp_cnt_next = ipp_fire ? 24'd0 : ipp_cnt + 24'd1;
      end
      if (busy && trig_evt) begin
        missed_next = sat_inc16(missed);
      end

      case (state)
        ST_IDLE: begin
          wcount_next  = '0;
          missed_next  = '0;
          ipp_cnt_next = '0;
          state_next   = ST_ARMED;
        end
        ST_ARMED: ;
        ST_DELAY: begin
          if (sh_delay == 24'd0) begin
            state_next = ST_WINDOW;
            cnt_next   = '0;
          end else if (rxstrobe) begin
            if (cnt == sh_delay - 24'd1) begin
              state_next = ST_WINDOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 24'd1;
            end
          end
        end
        ST_WINDOW: begin
          if (rxstrobe) begin
            if (cnt == sh_width - 24'd1) state_next = ST_HOLDOFF;
            else                         cnt_next   = cnt + 24'd1;
          end
        end
        ST_HOLDOFF: begin
          wcount_next = wcount + 16'd1;
          if ((sh_count != 16'd0) && (wcount_next == sh_count)) state_next = ST_DONE;
          else                                                   state_next = ST_ARMED;
        end
        ST_DONE: begin
          if (count_wr) begin
            state_next   = ST_ARMED;
            wcount_next  = '0;
            missed_next  = '0;
            ipp_cnt_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase

      // A trigger landing in IDLE (the cycle that arms) or ARMED is taken.
      // Shadows isolate the running window from later register writes.
      if (((state == ST_IDLE) || (state == ST_ARMED)) && trig_evt) begin
        sh_delay_next = delay_reg;
        sh_width_next = width_reg;
        sh_count_next = count_reg;
        cnt_next      = '0;
        state_next    = (width_reg == 24'd0) ? ST_ARMED : ST_DELAY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sh_delay <= '0;
      sh_width <= '0;
      sh_count <= '0;
      wcount   <= '0;
      missed   <= '0;
      ipp_cnt  <= '0;
      gate_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sh_delay <= sh_delay_next;
      sh_width <= sh_width_next;
      sh_count <= sh_count_next;
      wcount   <= wcount_next;
      missed   <= missed_next;
      ipp_cnt  <= ipp_cnt_next;
      gate_q   <= (state_next == ST_WINDOW);
    end
  end

  assign gate_enable  = gate_q;
  assign window_count = wcount;
  assign trig_missed  = missed;

endmodule
`default_nettype wire

// File: tb/tb_rx_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_gate_sequencer
// Description : Self-checking bench for rx_gate_sequencer: table of external
//               trigger windows plus directed sequences for missed triggers,
//               mid-window writes, disable, reset, internal mode and
//               trig_missed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_gate_sequencer;

  localparam logic [6:0] A_CTRL  = 7'd80;
  localparam logic [6:0] A_DELAY = 7'd81;
  localparam logic [6:0] A_WIDTH = 7'd82;
  localparam logic [6:0] A_IPP   = 7'd83;
  localparam logic [6:0] A_COUNT = 7'd84;

  logic        clock;
  logic        reset;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        rxstrobe;
  logic        trig_in;
  logic        gate_enable, busy, done;
  logic [15:0] window_count, trig_missed;

  int checks;
  int errors;
  int strobe_div;

  rx_gate_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .rxstrobe      (rxstrobe),
    .trig_in       (trig_in),
    .gate_enable   (gate_enable),
    .busy          (busy),
    .done          (done),
    .window_count  (window_count),
    .trig_missed   (trig_missed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // rxstrobe: one clock in every strobe_div clocks
  initial begin
    int ph;
    ph = 0;
    rxstrobe = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      ph = ph + 1;
      if (ph >= strobe_div) ph = 0;
      rxstrobe = (ph == 0);
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] dly;
    logic [23:0] wid;
    int          exp_lat;
    int          exp_dstr;
    int          exp_wstr;
    bit          exp_gate;
    int          exp_wc;
  } vec_t;

  vec_t vt[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    @(posedge clock);
    #1;
    serial_strobe = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_gate(input bit lvl, input int maxc, input string name);
    int n;
    n = 0;
    while (gate_enable !== lvl && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check(name, gate_enable, lvl);
    @(posedge clock);
    #1;
  endtask

  // Raise the pin, observe one window. lat = negedges until gate seen,
  // dstr = strobes before the gate (after the 3-clock sync latency),
  // wstr = strobes under the gate. Optionally fires extra trigger pulses
  // during the window, or rewrites WIDTH after wr_at gated strobes.
  task automatic run_window(input int max_clk, input int extra, input int wr_at,
                            input logic [31:0] wr_val, output int lat,
                            output int dstr, output int wstr, output bit gated);
    int n, ph, sent;
    bit closed, wr_active;
    n = 0; ph = 0; sent = 0; closed = 0; wr_active = 0;
    lat = -1; dstr = 0; wstr = 0; gated = 0;
    trig_in = 1'b1;
    while (n < max_clk && !closed) begin
      @(negedge clock);
      n++;
      if (wr_active) begin
        serial_strobe = 1'b0;
        wr_active = 0;
      end
      if (n == 3) trig_in = 1'b0;
      if (gate_enable) begin
        if (!gated) begin
          gated = 1;
          lat = n;
        end
        if (rxstrobe) begin
          wstr++;
          if (wstr == wr_at) begin
            serial_addr   = A_WIDTH;
            serial_data   = wr_val;
            serial_strobe = 1'b1;
            wr_active     = 1;
          end
        end
        if (sent < extra) begin
          if (ph == 0) trig_in = 1'b1;
          else if (ph == 2) begin
            trig_in = 1'b0;
            sent++;
          end
          ph = (ph + 1) % 4;
        end
      end else if (gated) begin
        closed = 1;
      end else if (n > 3 && rxstrobe) begin
        dstr++;
      end
    end
    serial_strobe = 1'b0;
    trig_in = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int lat, dstr, wstr;
    bit gated;
    int rises, sc;
    bit pg;

    checks = 0; errors = 0; strobe_div = 4;
    reset = 1'b1; serial_strobe = 1'b0; serial_addr = '0; serial_data = '0; trig_in = 1'b0;

    vt[0] = '{24'd10, 24'd20, -1, 10, 20, 1'b1, 1};
    vt[1] = '{24'd0,  24'd5,   5, -1,  5, 1'b1, 2};
    vt[2] = '{24'd3,  24'd1,  -1,  3,  1, 1'b1, 3};
    vt[3] = '{24'd5,  24'd0,  -1, -1,  0, 1'b0, 3};
    vt[4] = '{24'd1,  24'd7,  -1,  1,  7, 1'b1, 4};

    tick(3);
    reset = 1'b0;
    check("rst_gate", gate_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wc", window_count, 0);
    check("rst_missed", trig_missed, 0);

    // External trigger, continuous mode
    wr(A_CTRL, 32'd1);
    tick(2);
    check("armed_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      wr(A_DELAY, {8'd0, vt[i].dly});
      wr(A_WIDTH, {8'd0, vt[i].wid});
      tick(2);
      run_window(300, 0, 0, 32'd0, lat, dstr, wstr, gated);
      check($sformatf("v%0d_gate", i), gated, vt[i].exp_gate);
      if (vt[i].exp_lat >= 0)  check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      if (vt[i].exp_dstr >= 0) check($sformatf("v%0d_delay_strobes", i), dstr, vt[i].exp_dstr);
      check($sformatf("v%0d_width_strobes", i), wstr, vt[i].exp_wstr);
      tick(4);
      check($sformatf("v%0d_wc", i), window_count, vt[i].exp_wc);
      check($sformatf("v%0d_busy", i), busy, 0);
    end
    check("table_missed", trig_missed, 0);

    // Four extra triggers inside a window
    wr(A_DELAY, 32'd2);
    wr(A_WIDTH, 32'd60);
    tick(2);
    run_window(600, 4, 0, 32'd0, lat, dstr, wstr, gated);
    check("miss_width_strobes", wstr, 60);
    tick(4);
    check("miss_count", trig_missed, 4);
    check("miss_wc", window_count, 5);

    // WIDTH rewritten mid-window only affects the next window
    wr(A_WIDTH, 32'd20);
    tick(2);
    run_window(300, 0, 5, 32'd50, lat, dstr, wstr, gated);
    check("midwr_cur_width", wstr, 20);
    tick(4);
    run_window(600, 0, 0, 32'd0, lat, dstr, wstr, gated);
    check("midwr_next_width", wstr, 50);
    tick(4);
    check("midwr_wc", window_count, 7);

    // Reset in DELAY
    wr(A_DELAY, 32'd10);
    wr(A_WIDTH, 32'd20);
    trig_in = 1'b1;
    tick(3);
    trig_in = 1'b0;
    tick(3);
    check("rdly_busy_before", busy, 1);
    check("rdly_gate_before", gate_enable, 0);
    reset = 1'b1;
    tick(1);
    check("rdly_outs", {gate_enable, busy, done}, 0);
    check("rdly_wc", window_count, 0);
    check("rdly_missed", trig_missed, 0);
    reset = 1'b0;
    tick(1);

    // Reset in WINDOW (registers were cleared, so reprogram)
    wr(A_DELAY, 32'd2);
    wr(A_WIDTH, 32'd20);
    wr(A_CTRL, 32'd1);
    tick(2);
    trig_in = 1'b1;
    tick(3);
    trig_in = 1'b0;
    wait_gate(1'b1, 100, "rwin_gate_up");
    reset = 1'b1;
    tick(1);
    check("rwin_outs", {gate_enable, busy, done}, 0);
    reset = 1'b0;
    tick(1);

    // One normal window, then disable mid-window
    wr(A_DELAY, 32'd0);
    wr(A_WIDTH, 32'd3);
    wr(A_CTRL, 32'd1);
    tick(2);
    run_window(200, 0, 0, 32'd0, lat, dstr, wstr, gated);
    check("post_rst_width", wstr, 3);
    tick(4);
    check("post_rst_wc", window_count, 1);
    wr(A_WIDTH, 32'd30);
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
    wait_gate(1'b1, 50, "dis_gate_up");
    wr(A_CTRL, 32'd0);
    tick(1);
    check("dis_gate", gate_enable, 0);
    check("dis_busy", busy, 0);
    check("dis_done", done, 0);
    check("dis_wc_hold", window_count, 1);
    wr(A_CTRL, 32'd1);
    tick(1);
    check("reen_wc", window_count, 0);

    // Internal mode: IPP=100, DELAY=0, WIDTH=5, COUNT=3
    wr(A_CTRL, 32'd0);
    wr(A_DELAY, 32'd0);
    wr(A_WIDTH, 32'd5);
    wr(A_IPP, 32'd100);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'd3);
    rises = 0; sc = 0; pg = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      if (gate_enable && !pg) begin
        rises++;
        if (rises > 1) check($sformatf("int_spacing%0d", rises), sc, 100);
        sc = 0;
      end
      if (rxstrobe) sc++;
      pg = gate_enable;
    end
    tick(1);
    check("int_rises", rises, 3);
    check("int_done", done, 1);
    check("int_gate", gate_enable, 0);
    check("int_wc", window_count, 3);
    check("int_missed", trig_missed, 0);
    wr(A_COUNT, 32'd3);
    tick(1);
    check("rearm_done", done, 0);
    check("rearm_wc", window_count, 0);

    // trig_missed saturation: a trigger on every clock through a long window
    wr(A_CTRL, 32'd0);
    strobe_div = 1;
    wr(A_DELAY, 32'd0);
    wr(A_WIDTH, 32'd70000);
    wr(A_IPP, 32'd1);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'd3);
    wait_gate(1'b1, 50, "sat_gate_up");
    wait_gate(1'b0, 71000, "sat_gate_down");
    tick(3);
    check("sat_missed", trig_missed, 32'hFFFF);
    check("sat_wc", window_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
